// File: rtl/uart_cmd_parser_pkg.sv
// Shared types for the UART command path: parser, uart_sm and arithmetic units.
package uart_cmd_pkg;

    localparam int unsigned HDR_BYTES = 4;
    localparam int unsigned LEN_W     = 16;
    localparam int unsigned IDLE_W    = 24;

    typedef enum logic [1:0] {
        CMD_ADD = 2'd0,
        CMD_MUL = 2'd1,
        CMD_DIV = 2'd2
    } cmd_op_e;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_OPC     = 2'd1,
        ERR_LEN     = 2'd2,
        ERR_TIMEOUT = 2'd3
    } err_code_e;

    typedef enum logic [2:0] {
        ST_HDR0    = 3'd0,
        ST_HDR1    = 3'd1,
        ST_HDR2    = 3'd2,
        ST_HDR3    = 3'd3,
        ST_CHECK   = 3'd4,
        ST_CMD     = 3'd5,
        ST_PAYLOAD = 3'd6,
        ST_DRAIN   = 3'd7
    } parser_state_e;

endpackage

// File: rtl/uart_cmd_parser_if.sv
// Byte-in / descriptor+operand-out bus of the command parser.
// master = parser side, slave = UART receiver / downstream side.
interface uart_cmd_parser_if #(
    parameter int unsigned DW = 32
);
    logic [7:0]    rx_data_i;
    logic          rx_valid_i;
    logic          rx_ready_o;
    logic [1:0]    cmd_opcode_o;
    logic [15:0]   cmd_words_o;
    logic          cmd_valid_o;
    logic          cmd_ready_i;
    logic [DW-1:0] op_data_o;
    logic          op_last_o;
    logic          op_valid_o;
    logic          op_ready_i;
    logic          err_o;
    logic [1:0]    err_code_o;

    modport master (
        input  rx_data_i, rx_valid_i, cmd_ready_i, op_ready_i,
        output rx_ready_o, cmd_opcode_o, cmd_words_o, cmd_valid_o,
               op_data_o, op_last_o, op_valid_o, err_o, err_code_o
    );

    modport slave (
        output rx_data_i, rx_valid_i, cmd_ready_i, op_ready_i,
        input  rx_ready_o, cmd_opcode_o, cmd_words_o, cmd_valid_o,
               op_data_o, op_last_o, op_valid_o, err_o, err_code_o
    );
endinterface

// File: rtl/uart_cmd_parser_word_packer.sv
// uart_word_packer: collects bytes little-endian into a word, tags last,
// and holds the word until the consumer accepts it.
module uart_word_packer #(
    parameter int unsigned DW = 32
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clr_i,
    input  logic [7:0]    in_data_i,
    input  logic          in_valid_i,
    input  logic          in_last_i,
    output logic          in_ready_o,
    output logic          load_o,
    output logic [DW-1:0] out_data_o,
    output logic          out_last_o,
    output logic          out_valid_o,
    input  logic          out_ready_i
);

    localparam int unsigned BYTES = DW / 8;
    localparam int unsigned CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BYTES - 1);

    logic [BYTES-1:0][7:0] acc_q;
    logic [BYTES-1:0][7:0] word_c;
    logic [CNT_W-1:0]      cnt_q;
    logic [DW-1:0]         out_data_q;
    logic                  out_valid_q;
    logic                  out_last_q;
    logic                  in_ready_c;
    logic                  fire_c;

    // A new byte may enter while no word is pending or the pending one leaves now.
    assign in_ready_c = ~out_valid_q | out_ready_i;
    assign fire_c     = in_valid_i & in_ready_c;

    // Full word as it would look if the incoming byte completed it.
    always_comb begin
        word_c = acc_q;
        for (int unsigned i = 0; i < BYTES; i++) begin
            if (CNT_W'(i) == cnt_q) begin
                word_c[i] = in_data_i;
            end
        end
    end

    // Byte accumulation and output word register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else if (clr_i) begin
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            if (out_valid_q && out_ready_i) begin
                out_valid_q <= 1'b0;
            end
            if (fire_c) begin
                if (cnt_q == CNT_LAST) begin
                    out_data_q  <= word_c;
                    out_valid_q <= 1'b1;
                    out_last_q  <= in_last_i;
                    cnt_q       <= '0;
                end else begin
                    acc_q[cnt_q] <= in_data_i;
                    cnt_q        <= cnt_q + CNT_W'(1);
                end
            end
        end
    end

    assign in_ready_o  = in_ready_c;
    assign load_o      = fire_c & (cnt_q == CNT_LAST);
    assign out_data_o  = out_data_q;
    assign out_valid_o = out_valid_q;
    assign out_last_o  = out_last_q;

endmodule

// File: rtl/uart_cmd_parser.sv
// UART command framing stage: parses a 4-byte header, issues one descriptor,
// then streams the payload as little-endian operand words. Malformed packets
// are flagged on err_o/err_code_o and drained.
// Optional build macro: UART_CMD_PARSER_TIMEOUT_EN (idle abort, code 3).
module uart_cmd_parser
    import uart_cmd_pkg::*;
#(
    parameter int unsigned datawidth_p = 32,
    parameter int unsigned max_words_p = 255,
    parameter logic [7:0]  opc_add_p   = 8'h10,
    parameter logic [7:0]  opc_mul_p   = 8'h11,
    parameter logic [7:0]  opc_div_p   = 8'h12
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    uart_cmd_parser_if.master  bus
);

    localparam int unsigned BYTES = datawidth_p / 8;

    parser_state_e     state_q;
    logic [7:0]        opc_q;
    logic [7:0]        len_lo_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  words_q;
    logic [LEN_W-1:0]  drain_q;
    logic [LEN_W-1:0]  word_idx_q;
    logic [1:0]        cmd_opcode_q;
    logic [LEN_W-1:0]  cmd_words_q;
    logic              cmd_valid_q;
    logic              err_q;
    logic [1:0]        err_code_q;
    logic              out_en_q;

    logic [LEN_W-1:0]  len_c;
    logic [LEN_W-1:0]  words_c;
    logic [LEN_W-1:0]  rem_c;
    logic              opc_ok_c;
    logic              bad_len_c;
    cmd_op_e           opc_map_c;
    logic              rx_ready_c;
    logic              rx_fire_c;
    logic              cmd_fire_c;
    logic              op_fire_c;
    logic              pay_more_c;
    logic              pk_in_valid_c;
    logic              pk_in_ready_c;
    logic              pk_last_c;
    logic              pk_load_c;
    logic              abort_c;
    logic [datawidth_p-1:0] op_data_c;
    logic              op_valid_c;
    logic              op_last_c;

    // Header validation evaluated on the length MSB byte so err_o lands in CHECK.
    always_comb begin
        len_c     = {bus.rx_data_i, len_lo_q};
        words_c   = LEN_W'((len_c - LEN_W'(HDR_BYTES)) / LEN_W'(BYTES));
        rem_c     = LEN_W'((len_c - LEN_W'(HDR_BYTES)) % LEN_W'(BYTES));
        opc_ok_c  = (opc_q == opc_add_p) || (opc_q == opc_mul_p) || (opc_q == opc_div_p);
        bad_len_c = (len_c < LEN_W'(HDR_BYTES)) || (rem_c != '0) ||
                    (32'(words_c) > 32'(max_words_p));
        opc_map_c = CMD_ADD;
        if (opc_q == opc_mul_p) begin
            opc_map_c = CMD_MUL;
        end else if (opc_q == opc_div_p) begin
            opc_map_c = CMD_DIV;
        end
    end

    // Byte acceptance: header/drain states always, payload only while words remain.
    assign pay_more_c    = (word_idx_q != cmd_words_q);
    assign rx_ready_c    = out_en_q &
                           ((state_q inside {ST_HDR0, ST_HDR1, ST_HDR2, ST_HDR3, ST_DRAIN}) |
                            ((state_q == ST_PAYLOAD) & pay_more_c & pk_in_ready_c));
    assign rx_fire_c     = bus.rx_valid_i & rx_ready_c;
    assign cmd_fire_c    = cmd_valid_q & bus.cmd_ready_i;
    assign op_fire_c     = op_valid_c & bus.op_ready_i;
    assign pk_in_valid_c = bus.rx_valid_i & (state_q == ST_PAYLOAD) & pay_more_c;
    assign pk_last_c     = (word_idx_q == cmd_words_q - LEN_W'(1));

`ifdef UART_CMD_PARSER_TIMEOUT_EN
    logic [IDLE_W-1:0] idle_q;
    logic              activity_c;

    assign activity_c = rx_fire_c | cmd_fire_c | op_fire_c;
    assign abort_c    = (state_q != ST_HDR0) & ~activity_c & (idle_q == '1);

    // Idle watchdog: counts stalled cycles inside a packet.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            idle_q <= '0;
        end else if ((state_q == ST_HDR0) || activity_c || abort_c) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_q + IDLE_W'(1);
        end
    end
`else
    assign abort_c = 1'b0;
`endif

    uart_word_packer #(
        .DW (datawidth_p)
    ) u_packer (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clr_i       (abort_c),
        .in_data_i   (bus.rx_data_i),
        .in_valid_i  (pk_in_valid_c),
        .in_last_i   (pk_last_c),
        .in_ready_o  (pk_in_ready_c),
        .load_o      (pk_load_c),
        .out_data_o  (op_data_c),
        .out_last_o  (op_last_c),
        .out_valid_o (op_valid_c),
        .out_ready_i (bus.op_ready_i)
    );

    // Parser FSM with registered descriptor and error outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_HDR0;
            opc_q        <= '0;
            len_lo_q     <= '0;
            len_q        <= '0;
            words_q      <= '0;
            drain_q      <= '0;
            word_idx_q   <= '0;
            cmd_opcode_q <= '0;
            cmd_words_q  <= '0;
            cmd_valid_q  <= 1'b0;
            err_q        <= 1'b0;
            err_code_q   <= '0;
            out_en_q     <= 1'b0;
        end else begin
            out_en_q <= 1'b1;
            err_q    <= 1'b0;
            if (abort_c) begin
                state_q     <= ST_HDR0;
                err_q       <= 1'b1;
                err_code_q  <= ERR_TIMEOUT;
                cmd_valid_q <= 1'b0;
                word_idx_q  <= '0;
            end else begin
                if (pk_load_c) begin
                    word_idx_q <= word_idx_q + LEN_W'(1);
                end
                case (state_q)
                    ST_HDR0: begin
                        if (rx_fire_c) begin
                            opc_q   <= bus.rx_data_i;
                            state_q <= ST_HDR1;
                        end
                    end
                    ST_HDR1: begin
                        if (rx_fire_c) begin
                            state_q <= ST_HDR2;
                        end
                    end
                    ST_HDR2: begin
                        if (rx_fire_c) begin
                            len_lo_q <= bus.rx_data_i;
                            state_q  <= ST_HDR3;
                        end
                    end
                    ST_HDR3: begin
                        if (rx_fire_c) begin
                            len_q   <= len_c;
                            words_q <= words_c;
                            state_q <= ST_CHECK;
                            if (!opc_ok_c) begin
                                err_q      <= 1'b1;
                                err_code_q <= ERR_OPC;
                            end else if (bad_len_c) begin
                                err_q      <= 1'b1;
                                err_code_q <= ERR_LEN;
                            end
                        end
                    end
                    ST_CHECK: begin
                        if (err_q) begin
                            if (len_q > LEN_W'(HDR_BYTES)) begin
                                drain_q <= len_q - LEN_W'(HDR_BYTES);
                                state_q <= ST_DRAIN;
                            end else begin
                                state_q <= ST_HDR0;
                            end
                        end else begin
                            cmd_opcode_q <= opc_map_c;
                            cmd_words_q  <= words_q;
                            cmd_valid_q  <= 1'b1;
                            word_idx_q   <= '0;
                            state_q      <= ST_CMD;
                        end
                    end
                    ST_CMD: begin
                        if (cmd_fire_c) begin
                            cmd_valid_q <= 1'b0;
                            state_q     <= (words_q != '0) ? ST_PAYLOAD : ST_HDR0;
                        end
                    end
                    ST_PAYLOAD: begin
                        if (op_fire_c && op_last_c) begin
                            state_q <= ST_HDR0;
                        end
                    end
                    ST_DRAIN: begin
                        if (rx_fire_c) begin
                            drain_q <= drain_q - LEN_W'(1);
                            if (drain_q == LEN_W'(1)) begin
                                state_q <= ST_HDR0;
                            end
                        end
                    end
                    default: begin
                        state_q <= ST_HDR0;
                    end
                endcase
            end
        end
    end

    assign bus.rx_ready_o   = rx_ready_c;
    assign bus.cmd_opcode_o = cmd_opcode_q;
    assign bus.cmd_words_o  = cmd_words_q;
    assign bus.cmd_valid_o  = cmd_valid_q;
    assign bus.op_data_o    = op_data_c;
    assign bus.op_last_o    = op_last_c;
    assign bus.op_valid_o   = op_valid_c;
    assign bus.err_o        = err_q;
    assign bus.err_code_o   = err_code_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Self-checking bench for uart_cmd_parser: packet-level reference model,
// randomized byte gaps and ready patterns, directed corner packets.
module tb_uart_cmd_parser;

    localparam int unsigned DW = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    uart_cmd_parser_if #(.DW(DW)) bus ();

    uart_cmd_parser #(.datawidth_p(DW)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]  tx_q[$];
    logic [17:0] obs_cmd[$], exp_cmd[$];
    logic [32:0] obs_op[$],  exp_op[$];
    logic [1:0]  obs_err[$], exp_err[$];

    int p_valid   = 100;
    int p_cmd_rdy = 100;
    int p_op_rdy  = 100;
    bit hold_cmd  = 1'b0;
    bit hold_op   = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: what one packet must produce, derived from header rules.
    function automatic void model_packet(input logic [7:0] pkt[$]);
        logic [7:0]  opc = pkt[0];
        int          len = int'({pkt[3], pkt[2]});
        int          words;
        logic [31:0] w;
        if (!(opc inside {8'h10, 8'h11, 8'h12})) begin
            exp_err.push_back(2'd1);
        end else if (len < 4 || ((len - 4) % 4) != 0 || ((len - 4) / 4) > 255) begin
            exp_err.push_back(2'd2);
        end else begin
            words = (len - 4) / 4;
            exp_cmd.push_back({2'(opc - 8'h10), 16'(words)});
            for (int k = 0; k < words; k++) begin
                w = {pkt[4+4*k+3], pkt[4+4*k+2], pkt[4+4*k+1], pkt[4+4*k]};
                exp_op.push_back({(k == words - 1), w});
            end
        end
    endfunction

    task automatic send_bytes(input logic [7:0] pkt[$]);
        model_packet(pkt);
        foreach (pkt[i]) tx_q.push_back(pkt[i]);
    endtask

    task automatic send_pkt(input logic [7:0] opc, input int len);
        logic [7:0] pkt[$];
        pkt.push_back(opc);
        pkt.push_back(8'($urandom));
        pkt.push_back(8'(len));
        pkt.push_back(8'(len >> 8));
        for (int i = 0; i < len - 4; i++) pkt.push_back(8'($urandom));
        send_bytes(pkt);
    endtask

    // Driver and monitor: drive just after posedge, observe handshakes at negedge.
    initial begin
        bus.rx_valid_i  = 1'b0;
        bus.rx_data_i   = 8'h00;
        bus.cmd_ready_i = 1'b0;
        bus.op_ready_i  = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (tx_q.size() > 0 && $urandom_range(99) < p_valid) begin
                bus.rx_valid_i = 1'b1;
                bus.rx_data_i  = tx_q[0];
            end else begin
                bus.rx_valid_i = 1'b0;
                bus.rx_data_i  = 8'($urandom);
            end
            bus.cmd_ready_i = !hold_cmd && ($urandom_range(99) < p_cmd_rdy);
            bus.op_ready_i  = !hold_op  && ($urandom_range(99) < p_op_rdy);
            @(negedge clk);
            if (rst_n) begin
                if (bus.rx_valid_i && bus.rx_ready_o) void'(tx_q.pop_front());
                if (bus.cmd_valid_o && bus.cmd_ready_i)
                    obs_cmd.push_back({bus.cmd_opcode_o, bus.cmd_words_o});
                if (bus.op_valid_o && bus.op_ready_i)
                    obs_op.push_back({bus.op_last_o, bus.op_data_o});
                if (bus.err_o) obs_err.push_back(bus.err_code_o);
            end
        end
    end

    task automatic drain_wait(input string tag);
        int cyc = 0;
        while ((tx_q.size() != 0 || obs_cmd.size() < exp_cmd.size() ||
                obs_op.size() < exp_op.size() || obs_err.size() < exp_err.size())
               && cyc < 20000) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 20000) check({tag, "_timeout"}, 64'(cyc), 64'd0);
        repeat (20) @(negedge clk);
    endtask

    task automatic score(input string tag);
        check({tag, "_ncmd"}, 64'(obs_cmd.size()), 64'(exp_cmd.size()));
        check({tag, "_nop"},  64'(obs_op.size()),  64'(exp_op.size()));
        check({tag, "_nerr"}, 64'(obs_err.size()), 64'(exp_err.size()));
        for (int i = 0; i < obs_cmd.size() && i < exp_cmd.size(); i++)
            check($sformatf("%s_cmd%0d", tag, i), 64'(obs_cmd[i]), 64'(exp_cmd[i]));
        for (int i = 0; i < obs_op.size() && i < exp_op.size(); i++)
            check($sformatf("%s_op%0d", tag, i), 64'(obs_op[i]), 64'(exp_op[i]));
        for (int i = 0; i < obs_err.size() && i < exp_err.size(); i++)
            check($sformatf("%s_err%0d", tag, i), 64'(obs_err[i]), 64'(exp_err[i]));
        obs_cmd.delete(); exp_cmd.delete();
        obs_op.delete();  exp_op.delete();
        obs_err.delete(); exp_err.delete();
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_rx_ready"},  64'(bus.rx_ready_o),   64'd0);
        check({tag, "_cmd_valid"}, 64'(bus.cmd_valid_o),  64'd0);
        check({tag, "_cmd_opc"},   64'(bus.cmd_opcode_o), 64'd0);
        check({tag, "_cmd_words"}, 64'(bus.cmd_words_o),  64'd0);
        check({tag, "_op_valid"},  64'(bus.op_valid_o),   64'd0);
        check({tag, "_op_data"},   64'(bus.op_data_o),    64'd0);
        check({tag, "_op_last"},   64'(bus.op_last_o),    64'd0);
        check({tag, "_err"},       64'(bus.err_o),        64'd0);
        check({tag, "_err_code"},  64'(bus.err_code_o),   64'd0);
    endtask

    initial begin
        logic [7:0]  pkt[$];
        logic [31:0] held_data;
        logic [17:0] held_cmd;
        int          cyc;

        // Reset state
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        #2 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_rx_ready", 64'(bus.rx_ready_o), 64'd1);

        // Add packet, bad opcode + mul, bad lengths, word-count boundary
        pkt = '{8'h10, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00,
                8'h02, 8'h00, 8'h00, 8'h00};
        send_bytes(pkt);
        drain_wait("add");
        score("add");
        pkt = '{8'h7F, 8'h00, 8'h08, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        send_bytes(pkt);
        send_pkt(8'h11, 12);
        drain_wait("badopc");
        score("badopc");
        check("err_code_held_opc", 64'(bus.err_code_o), 64'd1);
        pkt = '{8'h11, 8'h00, 8'h07, 8'h00, 8'h01, 8'h02, 8'h03};
        send_bytes(pkt);
        pkt = '{8'h10, 8'h00, 8'h02, 8'h00};
        send_bytes(pkt);
        send_pkt(8'h12, 8);
        drain_wait("badlen");
        score("badlen");
        check("err_code_held_len", 64'(bus.err_code_o), 64'd2);
        send_pkt(8'h10, 4 + 4 * 255);
        send_pkt(8'h11, 4 + 4 * 256);
        send_pkt(8'h12, 4);
        drain_wait("maxwords");
        score("maxwords");

        // Zero-operand command with descriptor held under backpressure
        hold_cmd = 1'b1;
        pkt = '{8'h12, 8'h00, 8'h04, 8'h00};
        send_bytes(pkt);
        cyc = 0;
        while (!bus.cmd_valid_o && cyc < 200) begin @(negedge clk); cyc++; end
        check("cmdhold_seen", 64'(bus.cmd_valid_o), 64'd1);
        held_cmd = 18'h20000;
        repeat (5) begin
            @(negedge clk);
            check("cmdhold_valid", 64'(bus.cmd_valid_o), 64'd1);
            check("cmdhold_desc", 64'({bus.cmd_opcode_o, bus.cmd_words_o}), 64'(held_cmd));
        end
        hold_cmd = 1'b0;
        drain_wait("zero");
        score("zero");

        // Operand backpressure: no byte taken, word stable, order preserved
        hold_op = 1'b1;
        send_pkt(8'h10, 4 + 4 * 3);
        cyc = 0;
        while (!bus.op_valid_o && cyc < 200) begin @(negedge clk); cyc++; end
        check("bp_seen", 64'(bus.op_valid_o), 64'd1);
        held_data = bus.op_data_o;
        check("bp_first_word", 64'({bus.op_last_o, held_data}), 64'(exp_op[0]));
        repeat (10) begin
            @(negedge clk);
            check("bp_rx_ready", 64'(bus.rx_ready_o), 64'd0);
            check("bp_valid", 64'(bus.op_valid_o), 64'd1);
            check("bp_data", 64'(bus.op_data_o), 64'(held_data));
        end
        hold_op = 1'b0;
        drain_wait("bp");
        score("bp");

        // Randomized packet mix with random gaps and readies
        p_valid = 75; p_cmd_rdy = 60; p_op_rdy = 60;
        for (int n = 0; n < 40; n++) begin
            logic [7:0] opc;
            int         len;
            int         r;
            r = int'($urandom_range(9));
            opc = (r < 8) ? 8'(8'h10 + $urandom_range(2)) : 8'(8'h80 | $urandom_range(127));
            r = int'($urandom_range(19));
            if (r < 15)      len = 4 + 4 * int'($urandom_range(6));
            else if (r < 17) len = int'($urandom_range(3));
            else if (r < 19) len = 4 + 4 * int'($urandom_range(4)) + int'($urandom_range(1, 3));
            else             len = 4 + 4 * 256;
            send_pkt(opc, len);
        end
        drain_wait("rand");
        score("rand");

        // Asynchronous reset in the middle of a payload
        p_valid = 100; p_cmd_rdy = 100; p_op_rdy = 100;
        hold_op = 1'b1;
        send_pkt(8'h11, 4 + 4 * 4);
        cyc = 0;
        while (!bus.op_valid_o && cyc < 200) begin @(negedge clk); cyc++; end
        check("mid_seen", 64'(bus.op_valid_o), 64'd1);
        #2 rst_n = 1'b0;
        #1 check_outputs_zero("midrst");
        tx_q.delete();
        obs_cmd.delete(); exp_cmd.delete();
        obs_op.delete();  exp_op.delete();
        obs_err.delete(); exp_err.delete();
        hold_op = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        send_pkt(8'h10, 4 + 4 * 2);
        send_pkt(8'h12, 4 + 4 * 1);
        drain_wait("postrst");
        score("postrst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
